dff_delay_line: RTL

Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline. Each stage carries a valid flag. The pipeline has a global advance enable, a synchronous flush, a runtime-selectable tap output and a live occupancy count. It is the standard building block for aligning datapaths of differing latency and for retiming control/data buses between blocks.

---
 rtl/dff_delay_line.sv | 97 +++++++++
 1 files changed

// File: rtl/dff_delay_line.sv
// dff_delay_line: WIDTH-bit, DEPTH-stage register pipeline with a valid flag per stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; loads RST_VAL into data, clears valids
//   en         advance enable; the pipeline shifts one stage when high
//   clr        synchronous flush; takes priority over en
//   d          data into stage 0
//   d_valid    valid flag that travels with d
//   q          data of the last stage (DEPTH-1)
//   q_valid    valid flag of the last stage
//   tap_sel    stage index for the tap output
//   tap_q      data of stage tap_sel (RST_VAL when tap_sel is out of range)
//   tap_valid  valid flag of stage tap_sel (0 when tap_sel is out of range)
//   occ        number of stages currently holding valid data
module dff_delay_line #(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int unsigned     TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned     CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic [TW-1:0]    tap_sel,
   output logic [WIDTH-1:0] tap_q,
   output logic             tap_valid,
   output logic [CW-1:0]    occ
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [CW-1:0]    occ_q;
   logic [CW-1:0]    occ_d;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      occ_d  = occ_q;
      if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_d[i] = RST_VAL;
         end
         vld_d = '0;
         occ_d = '0;
      end else if (en) begin
         data_d[0] = d;
         vld_d[0]  = d_valid;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
         // Incoming valid enters while the last stage's valid leaves; the count stays in
         // 0..DEPTH because it always tracks the popcount of vld_q.
         occ_d = occ_q + CW'(d_valid) - CW'(vld_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= RST_VAL;
         end
         vld_q <= '0;
         occ_q <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         occ_q  <= occ_d;
      end
   end

   // Compare-based mux so an out-of-range tap_sel (non power-of-two DEPTH) falls to defaults.
   always_comb begin
      tap_q     = RST_VAL;
      tap_valid = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (TW'(i) == tap_sel) begin
            tap_q     = data_q[i];
            tap_valid = vld_q[i];
         end
      end
   end

   assign q       = data_q[DEPTH-1];
   assign q_valid = vld_q[DEPTH-1];
   assign occ     = occ_q;

endmodule
